uart_tx_arbiter: RTL and testbench

//   Shares one UART transmitter between NUM_REQ byte-stream requesters.

---
 rtl/uart_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit arbitration slice.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first request
// found scanning upward from ptr_i+1, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int off = 1; off <= N; off++) begin
            int idx;
            idx = (int'(ptr_i) + off) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx between NUM_REQ byte
// streams, with an idle timeout that reclaims the transmitter from a stalled owner.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]        req_last_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic [BYTE_W-1:0]         tx_data_out,
    output logic                      tx_valid_out,
    input  logic                      tx_ready_in,
    output logic [NUM_REQ-1:0]        grant_out,
    output logic                      busy_out,
    output logic                      timeout_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               own_valid;
    logic               own_last;
    logic [BYTE_W-1:0]  own_data;
    logic               xfer;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr (
        .req_i   (req_valid_in),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) arb_idx = IDX_W'(i);
        end
    end

    assign own_valid = req_valid_in[owner_q];
    assign own_last  = req_last_in[owner_q];
    assign own_data  = req_data_in[int'(owner_q)*BYTE_W +: BYTE_W];
    assign xfer      = (state_q == ARB_LOCKED) && own_valid && tx_ready_in;

    // Owner's handshake is passed straight through; everything is gated by
    // state_q so an async reset silences the outputs without a clock edge.
    always_comb begin
        tx_valid_out  = 1'b0;
        tx_data_out   = '0;
        req_ready_out = '0;
        grant_out     = '0;
        busy_out      = 1'b0;
        if (state_q == ARB_LOCKED) begin
            busy_out               = 1'b1;
            grant_out[owner_q]     = 1'b1;
            tx_valid_out           = own_valid;
            tx_data_out            = own_data;
            req_ready_out[owner_q] = tx_ready_in;
        end
    end

    assign timeout_out = timeout_q;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cnt_d = '0;
                if (|req_valid_in) begin
                    owner_d = arb_idx;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    cnt_d = '0;
                    if (own_last) begin
                        state_d = ARB_IDLE;
                        ptr_d   = owner_q;
                    end
                end else if (!own_valid && TO_EN) begin
                    // Only a silent owner ages; a busy uart_tx never counts against it.
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ARB_IDLE;
                        ptr_d     = owner_q;
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            owner_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16).
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_n),
        .req_valid_in  (req_valid),
        .req_data_in   (req_data),
        .req_last_in   (req_last),
        .req_ready_out (req_ready),
        .tx_data_out   (tx_data),
        .tx_valid_out  (tx_valid),
        .tx_ready_in   (tx_ready),
        .grant_out     (grant),
        .busy_out      (busy),
        .timeout_out   (timeout)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check_stream(input string tag);
        chk($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i),
                (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hxxxx_xxxx,
                {24'd0, exp_q[i]});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    int         bc[4];
    logic [3:0] acc;
    logic [3:0] gexp[15];
    bit         bad;
    int         idx;
    logic       tr;

    initial begin
        gexp = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4,
                 4'h0, 4'h8, 4'h8, 4'h0, 4'h1, 4'h1};

        // ---- 1: reset values, then req0 sends 41,42,43
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        chk("rst_txvalid", 32'(tx_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0000; tx_ready = 1'b1;
        mid();
        chk("t1_idle_grant", 32'(grant), 32'h0);
        chk("t1_idle_txvalid", 32'(tx_valid), 32'h0);
        chk("t1_idle_ready", 32'(req_ready), 32'h0);
        cyc();
        mid();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_b0", 32'(tx_data), 32'h41);
        chk("t1_b0_ready", 32'(req_ready), 32'h1);
        cyc();
        req_data[7:0] = 8'h42;
        mid();
        chk("t1_b1", 32'(tx_data), 32'h42);
        cyc();
        req_data[7:0] = 8'h43; req_last = 4'b0001;
        mid();
        chk("t1_b2", 32'(tx_data), 32'h43);
        chk("t1_busy_last", 32'(busy), 32'h1);
        cyc();
        clear_inputs();
        mid();
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_grant_after", 32'(grant), 32'h0);

        // ---- 2: four requesters, 2-byte packets, round-robin
        reset_dut();
        for (int i = 0; i < 4; i++) bc[i] = 0;
        exp_q = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h00, 8'h01};
        tx_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < 4; i++) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = 8'(i*16 + bc[i]);
                req_last[i]        = (bc[i] == 1);
            end
            mid();
            chk($sformatf("t2_grant_c%0d", c), 32'(grant), 32'(gexp[c]));
            acc = '0;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                acc = req_ready;
            end
            cyc();
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) bc[i] = (bc[i] == 1) ? 0 : 1;
            end
        end
        clear_inputs();
        check_stream("t2");

        // ---- 3: req2 stalls mid-packet, timeout releases to pending req3
        reset_dut();
        tx_ready = 1'b1;
        req_valid = 4'b0100; req_data[23:16] = 8'hA0;
        mid();
        cyc();
        mid();
        chk("t3_grant", 32'(grant), 32'h4);
        chk("t3_b0", 32'(tx_data), 32'hA0);
        cyc();
        req_valid = 4'b1000; req_data[31:24] = 8'h33; req_last = 4'b1000;
        bad = 1'b0;
        for (int k = 0; k < 16; k++) begin
            mid();
            if (busy !== 1'b1 || grant !== 4'h4 || timeout !== 1'b0 || tx_valid !== 1'b0) bad = 1'b1;
            cyc();
        end
        chk("t3_hold16", 32'(bad), 32'h0);
        mid();
        chk("t3_timeout_pulse", 32'(timeout), 32'h1);
        chk("t3_busy_released", 32'(busy), 32'h0);
        cyc();
        mid();
        chk("t3_timeout_one", 32'(timeout), 32'h0);
        chk("t3_grant3", 32'(grant), 32'h8);
        chk("t3_data3", 32'(tx_data), 32'h33);
        cyc();
        clear_inputs();

        // ---- 4: tx_ready low for 100 cycles, no timeout, data held
        reset_dut();
        req_valid = 4'b0001; req_data[7:0] = 8'h5A; req_last = 4'b0001; tx_ready = 1'b0;
        mid();
        cyc();
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            mid();
            if (tx_data !== 8'h5A || tx_valid !== 1'b1 || req_ready !== 4'h0 ||
                busy !== 1'b1 || timeout !== 1'b0) bad = 1'b1;
            cyc();
        end
        chk("t4_stall100", 32'(bad), 32'h0);
        tx_ready = 1'b1;
        mid();
        chk("t4_ready_rises", 32'(req_ready), 32'h1);
        cyc();
        clear_inputs();
        mid();
        chk("t4_done", 32'(busy), 32'h0);
        chk("t4_no_timeout", 32'(timeout), 32'h0);

        // ---- 5: async reset mid-packet
        reset_dut();
        tx_ready = 1'b1;
        req_valid = 4'b0001; req_data[7:0] = 8'h77; req_last = 4'b0001;
        mid();
        cyc();
        mid();
        chk("t5_pre_grant0", 32'(grant), 32'h1);
        cyc();
        req_valid = 4'b0010; req_data[15:8] = 8'h81; req_last = 4'b0000;
        mid();
        cyc();
        mid();
        chk("t5_grant1", 32'(grant), 32'h2);
        chk("t5_b0", 32'(tx_data), 32'h81);
        cyc();
        req_data[15:8] = 8'h82;
        mid();
        chk("t5_busy_before", 32'(busy), 32'h1);
        chk("t5_txvalid_before", 32'(tx_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        chk("t5_async_txvalid", 32'(tx_valid), 32'h0);
        chk("t5_async_ready", 32'(req_ready), 32'h0);
        cyc();
        rst_n = 1'b1;
        req_valid = 4'b0011; req_data[7:0] = 8'h01; req_last = 4'b0001;
        mid();
        chk("t5_idle_after", 32'(grant), 32'h0);
        cyc();
        mid();
        chk("t5_req0_first", 32'(grant), 32'h1);
        cyc();
        clear_inputs();

        // ---- 6: backpressure toggling during 4-byte packet
        reset_dut();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        idx = 0;
        tr  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            req_valid[0]  = (idx < 4);
            req_data[7:0] = 8'(8'h10 + idx);
            req_last[0]   = (idx == 3);
            tx_ready      = tr;
            mid();
            acc = '0;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                acc = req_ready;
            end
            cyc();
            if (acc[0]) idx++;
            tr = ~tr;
        end
        clear_inputs();
        mid();
        chk("t6_released", 32'(busy), 32'h0);
        check_stream("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
